floor_request_scheduler: RTL

- Parametrised successor to the single-vector floor request latch.
- Latches cab calls plus directional hall calls (up/down) per floor, clears them on arrival according to travel direction, and runs a SCAN (collective) direction FSM.
- Publishes the next target floor to the motion controller.
- Sits between the button/IO layer and the car motion controller.

---
 rtl/floor_request_scheduler.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// floor_request_scheduler
//
// Purpose:
//   Latches cab calls and directional hall calls per floor. Calls are cleared
//   when the car arrives, using the current travel direction to decide which
//   calls count as served. A SCAN (collective) direction FSM chooses the travel
//   direction, and the block publishes the next floor to stop at to the motion
//   controller.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   cab_req        in   [NUM_FLOORS]  cab button requests, bit i = floor i
//   hall_up_req    in   [NUM_FLOORS]  hall up-call requests (top floor ignored)
//   hall_down_req  in   [NUM_FLOORS]  hall down-call requests (floor 0 ignored)
//   current_floor  in   [FLOOR_WIDTH] floor the car is at or passing
//   at_floor       in   one-cycle strobe: car stopped at current_floor
//   cab_pending    out  [NUM_FLOORS]  latched cab calls
//   up_pending     out  [NUM_FLOORS]  latched hall up-calls
//   down_pending   out  [NUM_FLOORS]  latched hall down-calls
//   dir            out  [2]  00 IDLE, 01 UP, 10 DOWN
//   target_floor   out  [FLOOR_WIDTH] next floor to stop at
//   target_valid   out  target_floor is meaningful
//   any_pending    out  OR of all pending bits
//
// Optional feature (macro PARK_RETURN_EN):
//   After PARK_CYCLES idle cycles with nothing pending, a virtual cab call is
//   placed at HOME_FLOOR. That call is then served like any other call.
// -----------------------------------------------------------------------------
module floor_request_scheduler #(
    parameter int NUM_FLOORS  = 10,
    parameter int FLOOR_WIDTH = 4,
    parameter int HOME_FLOOR  = 0,
    parameter int PARK_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_FLOORS-1:0]  cab_req,
    input  logic [NUM_FLOORS-1:0]  hall_up_req,
    input  logic [NUM_FLOORS-1:0]  hall_down_req,
    input  logic [FLOOR_WIDTH-1:0] current_floor,
    input  logic                   at_floor,
    output logic [NUM_FLOORS-1:0]  cab_pending,
    output logic [NUM_FLOORS-1:0]  up_pending,
    output logic [NUM_FLOORS-1:0]  down_pending,
    output logic [1:0]             dir,
    output logic [FLOOR_WIDTH-1:0] target_floor,
    output logic                   target_valid,
    output logic                   any_pending
);

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    // The top floor has no up button and the ground floor has no down button.
    localparam logic [NUM_FLOORS-1:0] UP_MASK   = {1'b0, {(NUM_FLOORS-1){1'b1}}};
    localparam logic [NUM_FLOORS-1:0] DOWN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

    logic [NUM_FLOORS-1:0]  r_cab, r_up, r_down;
    logic                   r_any;
    dir_t                   r_dir;
    logic [FLOOR_WIDTH-1:0] r_target;
    logic                   r_target_valid;

    logic [31:0]            w_cf32;
    logic [NUM_FLOORS-1:0]  w_gt, w_lt, w_at;
    logic [NUM_FLOORS-1:0]  w_all;
    logic                   w_above, w_below, w_call_here;
    logic [NUM_FLOORS-1:0]  w_clr_cab, w_clr_up, w_clr_down;
    logic [NUM_FLOORS-1:0]  w_cab_next, w_up_next, w_down_next;
    logic [NUM_FLOORS-1:0]  w_park_vec;
    dir_t                   w_dir_next;
    logic [FLOOR_WIDTH-1:0] w_tgt_next;
    logic                   w_tgt_valid_next;

    assign w_cf32 = 32'(current_floor);
    assign w_all  = r_cab | r_up | r_down;

    // Per-floor position relative to the car. An out-of-range current_floor
    // makes w_at all zero, which also suppresses every clear.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_pos
        assign w_gt[gi] = 32'(gi) >  w_cf32;
        assign w_lt[gi] = 32'(gi) <  w_cf32;
        assign w_at[gi] = 32'(gi) == w_cf32;
    end

    assign w_above     = |(w_all & w_gt);
    assign w_below     = |(w_all & w_lt);
    assign w_call_here = |(w_all & w_at);

    // Arrival clears. A hall call for the opposite direction is only treated
    // as served when the car is about to reverse anyway.
    always_comb begin
        w_clr_cab  = '0;
        w_clr_up   = '0;
        w_clr_down = '0;
        if (at_floor) begin
            w_clr_cab = w_at;
            case (r_dir)
                DIR_UP: begin
                    w_clr_up = w_at;
                    if (!w_above) w_clr_down = w_at;
                end
                DIR_DOWN: begin
                    w_clr_down = w_at;
                    if (!w_below) w_clr_up = w_at;
                end
                default: begin
                    w_clr_up   = w_at;
                    w_clr_down = w_at;
                end
            endcase
        end
    end

`ifdef PARK_RETURN_EN
    localparam int PW = $clog2(PARK_CYCLES + 1);
    logic [PW-1:0] r_park_cnt;
    logic          w_park_req;

    // Counts idle-and-empty cycles, saturating at PARK_CYCLES.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_park_cnt <= '0;
        end else if (r_dir != DIR_IDLE || r_any) begin
            r_park_cnt <= '0;
        end else if (r_park_cnt != PW'(PARK_CYCLES)) begin
            r_park_cnt <= r_park_cnt + 1'b1;
        end
    end

    assign w_park_req = (r_dir == DIR_IDLE) && !r_any &&
                        (r_park_cnt == PW'(PARK_CYCLES)) &&
                        (w_cf32 != 32'(HOME_FLOOR));

    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_park
        assign w_park_vec[gi] = w_park_req && (gi == HOME_FLOOR);
    end
`else
    assign w_park_vec = '0;
`endif

    // Clear takes priority over a same-cycle request for the same bit.
    assign w_cab_next  = (r_cab  | cab_req | w_park_vec)    & ~w_clr_cab;
    assign w_up_next   = (r_up   | (hall_up_req & UP_MASK))   & ~w_clr_up;
    assign w_down_next = (r_down | (hall_down_req & DOWN_MASK)) & ~w_clr_down;

    // SCAN direction: keep going while there is work ahead, then reverse.
    always_comb begin
        w_dir_next = r_dir;
        case (r_dir)
            DIR_UP:   w_dir_next = w_above ? DIR_UP   : (w_below ? DIR_DOWN : DIR_IDLE);
            DIR_DOWN: w_dir_next = w_below ? DIR_DOWN : (w_above ? DIR_UP   : DIR_IDLE);
            default:  w_dir_next = w_above ? DIR_UP   : (w_below ? DIR_DOWN : DIR_IDLE);
        endcase
    end

    // Target selection. Prefer calls that agree with the travel direction;
    // otherwise head for the farthest call, where the car will reverse.
    always_comb begin
        logic [FLOOR_WIDTH-1:0] up_near, up_far, dn_near, dn_far;
        logic                   up_near_ok;
        logic                   dn_near_ok;
        up_near    = '0;
        up_far     = '0;
        dn_near    = '0;
        dn_far     = '0;
        up_near_ok = 1'b0;
        dn_near_ok = 1'b0;
        w_tgt_next       = r_target;
        w_tgt_valid_next = 1'b0;

        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (w_gt[i] && (r_cab[i] || r_up[i])) begin
                up_near    = FLOOR_WIDTH'(i);
                up_near_ok = 1'b1;
            end
            if (w_lt[i] && w_all[i]) dn_far = FLOOR_WIDTH'(i);
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_gt[i] && w_all[i]) up_far = FLOOR_WIDTH'(i);
            if (w_lt[i] && (r_cab[i] || r_down[i])) begin
                dn_near    = FLOOR_WIDTH'(i);
                dn_near_ok = 1'b1;
            end
        end

        case (w_dir_next)
            DIR_UP: begin
                w_tgt_next       = up_near_ok ? up_near : up_far;
                w_tgt_valid_next = 1'b1;
            end
            DIR_DOWN: begin
                w_tgt_next       = dn_near_ok ? dn_near : dn_far;
                w_tgt_valid_next = 1'b1;
            end
            default: begin
                if (w_call_here) begin
                    w_tgt_next       = current_floor;
                    w_tgt_valid_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cab          <= '0;
            r_up           <= '0;
            r_down         <= '0;
            r_any          <= 1'b0;
            r_dir          <= DIR_IDLE;
            r_target       <= '0;
            r_target_valid <= 1'b0;
        end else begin
            r_cab          <= w_cab_next;
            r_up           <= w_up_next;
            r_down         <= w_down_next;
            r_any          <= |(w_cab_next | w_up_next | w_down_next);
            r_dir          <= w_dir_next;
            r_target       <= w_tgt_next;
            r_target_valid <= w_tgt_valid_next;
        end
    end

    assign cab_pending  = r_cab;
    assign up_pending   = r_up;
    assign down_pending = r_down;
    assign any_pending  = r_any;
    assign dir          = r_dir;
    assign target_floor = r_target;
    assign target_valid = r_target_valid;

endmodule
